// File: rtl/gate16_bist_pkg.sv
// Shared definitions for the 16-bit gate BIST: op codes, FSM states,
// LFSR polynomial, directed vectors and the golden reference function.
package gate16_bist_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [15:0] VEC0_A = 16'h0000;
    localparam logic [15:0] VEC0_B = 16'h0000;
    localparam logic [15:0] VEC1_A = 16'hFFFF;
    localparam logic [15:0] VEC1_B = 16'h0000;
    localparam logic [15:0] VEC2_A = 16'hAAAA;
    localparam logic [15:0] VEC2_B = 16'h5555;

    function automatic logic [15:0] golden(input logic [1:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // Right-shifting Galois step: feed the shifted-out bit back through the mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/gate16_bist_lfsr16.sv
// 16-bit Galois LFSR with synchronous reseed; reset and load both restore the seed.
module lfsr16
    import gate16_bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/gate16_bist.sv
// BIST controller for a 16-bit two-operand gate: drives directed then
// pseudo-random operand pairs, compares the response and reports failures.
module gate16_bist
    import gate16_bist_pkg::*;
#(
    parameter int          NUM_VEC = 16,
    parameter int          SETTLE  = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    output logic [15:0] a_out,
    output logic [15:0] b_out,
    input  logic [15:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [7:0]  first_fail
);

    localparam logic [7:0] LAST_IDX    = 8'(NUM_VEC - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  fail_count_q, fail_count_d;
    logic [7:0]  first_fail_q, first_fail_d;
    logic [1:0]  op_q, op_d;

    logic        start_accept;
    logic        lfsr_step;
    logic        mismatch;
    logic [15:0] lfsr_a_q;
    logic [15:0] lfsr_b_q;

    assign start_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // The LFSRs advance on the edge that enters a random vector, so vector 3
    // already sees the first stepped value rather than the seed.
    assign lfsr_step = (state_q == ST_SAMPLE) && (index_q >= 8'd2) && (index_q != LAST_IDX);

    lfsr16 u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .load  (start_accept),
        .seed  (SEED),
        .step  (lfsr_step),
        .q     (lfsr_a_q)
    );

    lfsr16 u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .load  (start_accept),
        .seed  (SEED ^ 16'h5A5A),
        .step  (lfsr_step),
        .q     (lfsr_b_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= 8'd0;
            settle_q     <= 4'd0;
            fail_count_q <= 8'd0;
            first_fail_q <= 8'hFF;
            op_q         <= OP_AND;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            settle_q     <= settle_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            op_q         <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
            ST_APPLY:         if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE:        state_d = (index_q == LAST_IDX) ? ST_DONE : ST_APPLY;
            default:          state_d = ST_IDLE;
        endcase
    end

    assign mismatch = (dut_out != golden(op_q, a_out, b_out));

    always_comb begin
        index_d      = index_q;
        settle_d     = settle_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        op_d         = op_q;
        if (start_accept) begin
            index_d      = 8'd0;
            settle_d     = 4'd0;
            fail_count_d = 8'd0;
            first_fail_d = 8'hFF;
            op_d         = op;
        end else if (state_q == ST_APPLY) begin
            settle_d = (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
        end else if (state_q == ST_SAMPLE) begin
            if (mismatch) begin
                if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
                if (first_fail_q == 8'hFF) first_fail_d = index_q;
            end
            if (index_q != LAST_IDX) index_d = index_q + 8'd1;
        end
    end

    always_comb begin
        busy  = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
        done  = (state_q == ST_DONE);
        pass  = done && (fail_count_q == 8'd0);
        a_out = 16'h0000;
        b_out = 16'h0000;
        if (busy) begin
            case (index_q)
                8'd0: begin a_out = VEC0_A;   b_out = VEC0_B;   end
                8'd1: begin a_out = VEC1_A;   b_out = VEC1_B;   end
                8'd2: begin a_out = VEC2_A;   b_out = VEC2_B;   end
                default: begin a_out = lfsr_a_q; b_out = lfsr_b_q; end
            endcase
        end
    end

    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: doc/gate16_bist.md
GATE16_BIST -- requirements
Module: gate16_bist

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 16, meaning the total vectors per run (range 3..255).
REQ-002 The block SHALL have parameter SETTLE, default 1, meaning the cycles that a_out/b_out are held before dut_out is sampled (range 1..15).
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, meaning the operand-A LFSR seed (nonzero, not 16'h5A5A).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, width 1: one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-007 The block SHALL have port op, input, width 2: the golden function; 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~a. It is sampled when start is accepted.
REQ-008 The block SHALL have port a_out, output, width 16: operand driven to the DUT.
REQ-009 The block SHALL have port b_out, output, width 16: operand driven to the DUT.
REQ-010 The block SHALL have port dut_out, input, width 16: the combinational DUT response.
REQ-011 The block SHALL have port busy, output, width 1: high while a run is in progress.
REQ-012 The block SHALL have port done, output, width 1: high in DONE until the next start or reset.
REQ-013 The block SHALL have port pass, output, width 1: valid when done is high; 1 if fail_count == 0.
REQ-014 The block SHALL have port fail_count, output, width 8: mismatches in the current or last run; saturates at 255.
REQ-015 The block SHALL have port first_fail, output, width 8: index of the first mismatching vector; 8'hFF if there was none.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, SAMPLE and DONE.
- IDLE/DONE + start -> APPLY; this clears the vector index, fail_count and first_fail, and latches op.
- APPLY holds the vector for SETTLE cycles -> SAMPLE.
- SAMPLE -> APPLY if index < NUM_VEC-1 (increment index), else -> DONE.
REQ-017 Each vector SHALL occupy exactly SETTLE+1 cycles, and a run SHALL take NUM_VEC*(SETTLE+1) cycles from start to done rising.
REQ-018 Vectors 0, 1 and 2 SHALL be fixed: (0000,0000), (FFFF,0000), (AAAA,5555).
REQ-019 Vectors 3 onward SHALL be pseudo-random: a_out from a 16-bit Galois LFSR A (mask 16'hB400, seeded SEED), and b_out from LFSR B (same mask, seeded SEED^16'h5A5A).
- Both LFSRs are reseeded at start.
- Both advance once per SAMPLE cycle, for vectors at index >= 3 only.
REQ-020 In SAMPLE the block SHALL compare dut_out against golden(op, a_out, b_out).
- Mismatch increments fail_count, saturating at 255.
- The first mismatch records the index in first_fail.
REQ-021 a_out/b_out SHALL be stable throughout APPLY and SAMPLE of a vector, and SHALL change only on the SAMPLE->APPLY edge.
REQ-022 In IDLE and DONE, a_out and b_out SHALL be 16'h0000.
REQ-023 start asserted while busy SHALL be ignored, with no restart and no state change.
REQ-024 start in DONE SHALL begin a new run next cycle; done falls and busy rises on the same edge.
REQ-025 Changes on op while busy SHALL have no effect on the current run.
REQ-026 pass SHALL be 0 whenever done is 0.

Reset
REQ-027 Reset SHALL be synchronous: effective only on a rising clk edge with reset high.
REQ-028 Reset SHALL force state IDLE, busy = 0, done = 0, pass = 0, fail_count = 0, first_fail = 8'hFF, a_out = b_out = 0, index = 0, and LFSRs = their seeds.
REQ-029 Reset asserted mid-run SHALL abort the run and discard its results; reset has priority over start in the same cycle.

Structure
REQ-030 A shared package SHALL hold:
- the op encoding constants (OP_AND, OP_OR, OP_XOR, OP_NOT);
- the FSM state encoding;
- the LFSR mask 16'hB400;
- the three directed vector constants.
REQ-031 The LFSR SHALL be one sub-module, lfsr16, with ports clk, reset, load, seed[15:0], step and q[15:0], instantiated twice.
REQ-032 The golden function SHALL be a combinational function in the package, not a separate module.

Verification
REQ-033 Bench with an ideal OR DUT (dut_out = a_out|b_out), op = 01, start pulse -> busy for 32 cycles, done = 1, pass = 1, fail_count = 0, first_fail = FF.
REQ-034 Bench with an OR DUT but op = 00 -> vector 1 (FFFF,0000) mismatches; first_fail = 1, and fail_count >= 2 (vector 2 also mismatches: FFFF vs 0000).
REQ-035 Bench with a DUT whose bit 15 is stuck at 0, op = 01 -> first_fail = 1 (expected FFFF, got 7FFF), pass = 0.
REQ-036 Assert reset at cycle 10 of a run -> next cycle state is IDLE, busy = 0, a_out = 0, and first_fail = FF; a later start gives results identical to a clean run.
REQ-037 Pulse start at cycle 5 of a run -> completion cycle and results are unchanged; start in DONE -> done = 0 and busy = 1 the next cycle.
REQ-038 Run twice with the same SEED -> a_out/b_out sequences are bit-identical; vector 3 a_out = the LFSR A step from 16'hACE1.
